// File: rtl/x2050_pkg.sv
// Shared types and constants for the 2050 channel request sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arbiter FSM state enum, command bit positions, WM write-channel-command
// code, and the L register field that carries the channel select.
package x2050_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  // Bit positions within the latched command byte.
  typedef enum int {
    CMD_INT_TEST_IO   = 0,
    CMD_TIMEOUT_CHECK = 1,
    CMD_TIMEOUT       = 2,
    CMD_FOUL          = 3,
    CMD_TEST_CHANNEL  = 4,
    CMD_TEST_IO       = 5,
    CMD_HALT_IO       = 6,
    CMD_START_IO      = 7
  } cmd_bit_e;

  localparam logic [3:0] WM_WCC = 4'd7;

  localparam int L_CHSEL_LO = 8;
  localparam int L_CHSEL_HI = 10;

endpackage

// File: rtl/x2050_rr_arb.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller holds ptr and request stable while sampling.
// Ports: i_req (NCH requests), i_ptr (start index) -> o_gnt (one-hot),
//        o_idx (granted index), o_any (any request set).
module x2050_rr_arb #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [PW-1:0]  o_idx,
  output logic           o_any
);

  always_comb begin : p_enc
    logic [PW:0] pos;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    pos   = '0;
    for (int i = 0; i < NCH; i++) begin
      // One extra bit so ptr + offset can exceed NCH before the wrap.
      pos = {1'b0, i_ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(NCH)) pos = pos - (PW+1)'(NCH);
      if (!o_any && i_req[pos[PW-1:0]]) begin
        o_any      = 1'b1;
        o_gnt[pos[PW-1:0]] = 1'b1;
        o_idx      = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/x2050chseq.sv
// Channel request sequencer: WCC decode, command/channel latch, request history, RR arbiter.
// Latency: o_wcc combinational; latches 1 cycle; grant 2 cycles after stage 0 loads.
// Backpressure: grant held until i_grant_ack (or timeout when X2050_GRANT_TIMEOUT_EN is defined).
// Ports: ROS decode inputs (i_ros_advance, i_io_mode, i_wm, i_io_instruction), data inputs
// (i_l_reg, i_buffer_out_bus), history qualifiers (i_firstcycle, i_routine_recd),
// i_routine_requesting, clear events, i_grant_ack, i_tmo_limit; outputs o_wcc, o_ch_select,
// o_command, o_hist, o_grant, o_grant_valid, o_timeout_check.
module x2050chseq
  import x2050_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int HDEPTH = 3,
  parameter int CHW    = 3,
  parameter int TMO_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ros_advance,
  input  logic                  i_io_mode,
  input  logic [3:0]            i_wm,
  input  logic [31:0]           i_l_reg,
  input  logic [8:0]            i_buffer_out_bus,
  input  logic                  i_io_instruction,
  input  logic                  i_firstcycle,
  input  logic                  i_routine_recd,
  input  logic [NCH-1:0]        i_routine_requesting,
  input  logic                  i_reset_c1,
  input  logic                  i_reply_latch_pulse,
  input  logic                  i_grant_ack,
  input  logic [TMO_W-1:0]      i_tmo_limit,
  output logic                  o_wcc,
  output logic [CHW-1:0]        o_ch_select,
  output logic [7:0]            o_command,
  output logic [HDEPTH*NCH-1:0] o_hist,
  output logic [NCH-1:0]        o_grant,
  output logic                  o_grant_valid,
  output logic                  o_timeout_check
);

  localparam int PW = $clog2(NCH);

  logic           w_wcc_g, w_clr, w_set_odd, w_set_even;
  logic [CHW-1:0] w_lsel;
  logic [7:0]     r_command;
  logic [CHW-1:0] r_ch_select;
  logic [NCH-1:0] r_hist [HDEPTH];

  arb_state_t     r_state, w_state_nxt;
  logic [NCH-1:0] r_grant, w_grant_nxt;
  logic           r_gvld, w_gvld_nxt;
  logic [PW-1:0]  r_gidx, w_gidx_nxt, r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [NCH-1:0] w_arb_gnt;
  logic [PW-1:0]  w_arb_idx;
  logic           w_arb_any, w_tmo;
  logic           w_unused;

  assign o_wcc      = i_ros_advance & ~i_io_mode & (i_wm == WM_WCC);
  assign w_wcc_g    = o_wcc & ~i_io_instruction;
  assign w_clr      = i_reset_c1 | i_reply_latch_pulse;
  assign w_set_odd  = i_routine_recd & i_ros_advance;
  assign w_set_even = i_firstcycle & i_ros_advance;
  assign w_lsel     = CHW'(i_l_reg[L_CHSEL_HI:L_CHSEL_LO]);

  // Clear is applied after the load so it overrides foul and channel select.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_command   <= '0;
      r_ch_select <= '0;
    end else begin
      if (w_wcc_g) begin
        r_command   <= i_buffer_out_bus[7:0];
        r_ch_select <= w_lsel;
      end
      if (w_clr) begin
        r_command[CMD_FOUL] <= 1'b0;
        r_ch_select         <= '0;
      end
    end
  end

  assign o_command   = r_command;
  assign o_ch_select = r_ch_select;

  // Odd/even stages shift on alternating qualifiers; with both qualifiers set,
  // every stage takes its neighbour's pre-edge value.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < HDEPTH; s++) r_hist[s] <= '0;
    end else begin
      if (w_set_odd) r_hist[0] <= i_routine_requesting;
      for (int s = 1; s < HDEPTH; s++) begin
        if ((s % 2 == 0) && w_set_odd)  r_hist[s] <= r_hist[s-1];
        if ((s % 2 == 1) && w_set_even) r_hist[s] <= r_hist[s-1];
      end
    end
  end

  for (genvar s = 0; s < HDEPTH; s++) begin : g_hist
    assign o_hist[s*NCH +: NCH] = r_hist[s];
  end

  x2050_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
    .i_req (r_hist[0]),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_ptr_adv = (r_gidx == PW'(NCH - 1)) ? '0 : r_gidx + PW'(1);

`ifdef X2050_GRANT_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  // Cleared while in ARB, i.e. on every HOLD entry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                r_tmo_cnt <= '0;
    else if (r_state == ST_ARB)                    r_tmo_cnt <= '0;
    else if (r_state == ST_HOLD && !i_grant_ack)   r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  assign w_tmo    = (r_state == ST_HOLD) && !i_grant_ack && (r_tmo_cnt == i_tmo_limit);
  assign w_unused = ^{i_l_reg[31:L_CHSEL_HI+1], i_l_reg[L_CHSEL_LO-1:0], i_buffer_out_bus[8]};
`else
  assign w_tmo    = 1'b0;
  assign w_unused = ^{i_l_reg[31:L_CHSEL_HI+1], i_l_reg[L_CHSEL_LO-1:0], i_buffer_out_bus[8],
                      i_tmo_limit};
`endif

  assign o_timeout_check = w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gvld_nxt  = r_gvld;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: if (r_hist[0] != '0) w_state_nxt = ST_ARB;
      ST_ARB: begin
        if (w_arb_any) begin
          w_grant_nxt = w_arb_gnt;
          w_gvld_nxt  = 1'b1;
          w_gidx_nxt  = w_arb_idx;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (i_grant_ack || w_tmo) begin
          w_grant_nxt = '0;
          w_gvld_nxt  = 1'b0;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gvld  <= 1'b0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gvld  <= w_gvld_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_gvld;

endmodule
